// File: rtl/axi_lite_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read channel among NUM_REQ word-indexed requesters.
// Latency: 3 cycles from accept to resp_valid with a zero-wait slave. One read outstanding; req_ready only in IDLE.
module axi_lite_read_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_idx,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_err,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  output logic [2:0]              s_axil_arprot,
  output logic                    s_axil_arvalid,
  input  logic                    s_axil_arready,
  input  logic [DATA_WIDTH-1:0]   s_axil_rdata,
  input  logic [1:0]              s_axil_rresp,
  input  logic                    s_axil_rvalid,
  output logic                    s_axil_rready
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   owner, rr_ptr, grant_idx, owner_inc, scan_idx;
  logic            grant_vld;
  logic [31:0]     grant_word;
  int              scan;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_word = '0;
    scan       = 0;
    scan_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      scan_idx = IW'(scan);
      if (req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IW'(k) == grant_idx) grant_word = req_idx[32*k +: 32];
    end
  end

  assign owner_inc = (int'(owner) == NUM_REQ - 1) ? '0 : owner + IW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    resp_valid    = '0;
    s_axil_rready = 1'b0;
    busy          = (state != IDLE);
    s_axil_arprot = 3'b000;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req_ready = NUM_REQ'(1) << grant_idx;
          state_nxt = ADDR;
        end
      end
      ADDR: if (s_axil_arready) state_nxt = DATA;
      DATA: begin
        s_axil_rready = 1'b1;
        if (s_axil_rvalid) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = NUM_REQ'(1) << owner;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner          <= '0;
      rr_ptr         <= '0;
      s_axil_araddr  <= '0;
      s_axil_arvalid <= 1'b0;
      resp_data      <= '0;
      resp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner          <= grant_idx;
            s_axil_araddr  <= ADDR_WIDTH'({grant_word, 2'b00});
            s_axil_arvalid <= 1'b1;
          end
        end
        ADDR: if (s_axil_arready) s_axil_arvalid <= 1'b0;
        DATA: begin
          if (s_axil_rvalid) begin
            resp_data <= s_axil_rdata;
            resp_err  <= (s_axil_rresp != 2'b00);
          end
        end
        RESP: rr_ptr <= owner_inc;
        default: ;
      endcase
    end
  end

endmodule
